// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// arbiter state type, starvation counter width and a saturating increment.
package dmem_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_RSVD = 2'd2;
  localparam logic [1:0] DSIZE_WORD = 2'd3;

  localparam int STARVE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter: counts contested cycles lost by the aux
// requester, cleared when aux withdraws or is granted.
module arb_starve_ctr
  import dmem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [STARVE_W-1:0] count
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);
  localparam logic [STARVE_W-1:0] ONE_C = STARVE_W'(1);

  // Counter register; clear dominates increment, increment stops at MAX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {STARVE_W{1'b0}};
    end else if (clr) begin
      count <= {STARVE_W{1'b0}};
    end else if (inc && (count != MAX_C)) begin
      count <= count + ONE_C;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU load/store path and an aux
// requester. Define DMEM_ARB_STATS_EN to add stat_conflicts/stat_aux counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_dsize,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [1:0]        aux_dsize,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [1:0]        mem_dsize,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_aux
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state_r;
  logic [STARVE_W-1:0] starve_s;
  logic                aux_grant_s;
  logic                aux_mem_s;
  logic                aux_rsvd_s;
  logic                contested_s;
  logic                starve_inc_s;
  logic                starve_clr_s;

  assign contested_s  = (state_r == IDLE) && aux_req && cpu_req;
  assign aux_grant_s  = (state_r == IDLE) && aux_req && (!cpu_req || (starve_s == STARVE_LIM));
  assign aux_rsvd_s   = (aux_dsize == DSIZE_RSVD);
  // A reserved-size aux grant completes the handshake but leaves the port to the CPU.
  assign aux_mem_s    = aux_grant_s && !aux_rsvd_s;
  assign starve_inc_s = contested_s && !aux_grant_s;
  assign starve_clr_s = !aux_req || aux_grant_s;

  assign cpu_stall = cpu_req && aux_mem_s;
  assign cpu_rdata = mem_rdata;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clock (clock),
    .reset (reset),
    .clr   (starve_clr_s),
    .inc   (starve_inc_s),
    .count (starve_s)
  );

  // Memory port mux: aux fields when aux owns the port, otherwise CPU fields.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_dsize = cpu_dsize;
    mem_we    = 1'b0;
    if (aux_mem_s) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_dsize = aux_dsize;
      mem_we    = aux_we;
    end else begin
      mem_we    = cpu_req && cpu_we;
    end
  end

  // Handshake FSM with registered ack and captured aux read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      aux_ack   <= 1'b0;
      aux_rdata <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (aux_grant_s) begin
            state_r   <= ACK;
            aux_ack   <= 1'b1;
            aux_rdata <= aux_rsvd_s ? {DATA_W{1'b0}} : mem_rdata;
          end else begin
            state_r   <= IDLE;
            aux_ack   <= 1'b0;
            aux_rdata <= aux_rdata;
          end
        end
        ACK: begin
          state_r   <= IDLE;
          aux_ack   <= 1'b0;
          aux_rdata <= aux_rdata;
        end
        default: begin
          state_r   <= IDLE;
          aux_ack   <= 1'b0;
          aux_rdata <= aux_rdata;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating conflict and aux-grant counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_conflicts <= 16'd0;
      stat_aux       <= 16'd0;
    end else begin
      stat_conflicts <= contested_s ? sat_inc16(stat_conflicts) : stat_conflicts;
      stat_aux       <= aux_grant_s ? sat_inc16(stat_aux) : stat_aux;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory port between the CPU load/store path and an auxiliary requester (program loader / debug port). CPU accesses win by default and complete in the same cycle. Aux accesses use a req/ack handshake, with a starvation counter that guarantees aux progress. The block sits between the datapath's ALU/store-extender outputs and the dmem instance, and returns a stall to the instruction fetch unit when the CPU loses a cycle.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive contested cycles the CPU may win before aux is forced through (1..15)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU load or store this cycle
- cpu_we  in  1  CPU store
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data, already size-extended
- cpu_dsize  in  2  0 byte, 1 half, 3 word, 2 reserved
- cpu_rdata  out  DATA_W  combinational read data from mem_rdata
- cpu_stall  out  1  CPU access not performed this cycle; hold the PC and suppress regwrite/memwrite
- aux_req  in  1  aux request; held stable until aux_ack
- aux_we, aux_addr, aux_wdata, aux_dsize  in  1/ADDR_W/DATA_W/2  as for the CPU
- aux_ack  out  1  one-cycle pulse: aux access done
- aux_rdata  out  DATA_W  registered read data, valid while aux_ack is high
- mem_addr, mem_wdata, mem_we, mem_dsize  out  ADDR_W/DATA_W/1/2  to dmem
- mem_rdata  in  DATA_W  combinational dmem read data

## Operation
- States: IDLE, ACK.
- IDLE grant:
  - aux wins when aux_req && (!cpu_req || starve == STARVE_MAX).
  - Otherwise the CPU wins when cpu_req.
  - Otherwise no grant, mem_we=0.
- mem_* is a combinational mux of the granted requester. With no grant it carries the CPU fields and mem_we=0.
- cpu_stall = cpu_req && aux granted.
- Aux grant in IDLE:
  - Capture mem_rdata into aux_rdata.
  - Next state ACK; the starve counter resets to 0.
- ACK state:
  - aux_ack=1.
  - Aux is never granted; the CPU is granted if cpu_req.
  - Unconditional return to IDLE, so back-to-back aux accesses run every 2 cycles at most.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each IDLE cycle where both requests are present and the CPU wins.
  - Clears when aux_req is low.
- aux_dsize == 2 (reserved): no memory access (mem_we=0), the CPU is not stalled, and the handshake completes normally with aux_rdata = 0.
- cpu_dsize == 2 passes through unchanged. Handling it is dmem's concern.

## Timing
- Reset values: state IDLE, starve 0, aux_ack 0, aux_rdata 0, cpu_stall 0, mem_we 0.
- CPU access: zero latency, same cycle as cpu_req when not stalled.
- Aux access: grant in cycle N, aux_ack and aux_rdata in cycle N+1. Minimum latency 1 cycle.
- Worst-case aux latency under continuous CPU traffic: STARVE_MAX+1 cycles from aux_req to grant, +1 to ack.
- A simultaneous aux_req rise and CPU request with starve < STARVE_MAX goes to the CPU.
- An aux write is committed by dmem at the grant-cycle clock edge.
- aux_req dropped before ack (protocol violation): if not yet granted, the request is abandoned. If already granted, the ack is still issued.
- Reset asserted mid-handshake forces IDLE immediately. The pending aux_ack is lost and the requester must re-request.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_conflicts (16 bit, counts IDLE cycles with both requests present) and stat_aux (16 bit, counts aux grants).
  - Both saturate at 0xFFFF and reset to 0.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package dmem_pkg holds:
  - dsize encodings: DSIZE_BYTE=0, DSIZE_HALF=1, DSIZE_RSVD=2, DSIZE_WORD=3.
  - State enum arb_state_t {IDLE, ACK}.
  - STARVE_W width constant (4).
- One natural sub-module: arb_starve_ctr, the saturating starvation counter with clear and increment inputs. Everything else is flat.

## Test plan
- Reset, then aux_req with cpu_req=0, aux_addr=0x40, aux_we=1, aux_wdata=0xDEADBEEF, dsize=3 -> mem_we=1 in the same cycle, aux_ack next cycle. A CPU word load from 0x40 then returns 0xDEADBEEF.
- cpu_req held high continuously with aux_req held high, STARVE_MAX=4 -> the CPU wins 4 cycles, then cpu_stall=1 for exactly one cycle with aux granted, then aux_ack=1 while the CPU proceeds.
- Back-to-back aux reads of 0x0 and 0x4, no CPU traffic -> grants in cycles N and N+2, with aux_rdata matching memory on each ack.
- aux_dsize=2 with cpu_req=0 -> mem_we=0, aux_ack next cycle, aux_rdata=0.
- Reset pulsed in the ACK cycle -> aux_ack=0 and state IDLE immediately. A re-request completes normally.
- With DMEM_ARB_STATS_EN, 10 contested cycles -> stat_conflicts=10 and stat_aux=2 (STARVE_MAX=4).
